// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 brute-force key search controller:
//   - rc4_ctrl_state_t : sequencer state encoding (also used as the S-memory
//                        mux select and exported for debug)
//   - KEY_W / SMEM_AW / MSG_AW : key width, S-memory address width, and the
//                        width of a 0..MSG_LEN-1 byte index
//   - is_valid_char()  : plaintext acceptance test (lower-case ASCII or space)
// -----------------------------------------------------------------------------
package rc4_pkg;

    localparam int KEY_W   = 24;
    localparam int SMEM_AW = 8;
    localparam int MSG_AW  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_INIT_WAIT,
        ST_KSA,
        ST_KSA_WAIT,
        ST_DEC,
        ST_DEC_WAIT,
        ST_CHECK,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_FAIL
    } rc4_ctrl_state_t;

    // A decrypted byte is plausible plaintext when it is 'a'..'z' or ' '.
    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

endpackage

// File: rtl/rc4_smem_mux.sv
// -----------------------------------------------------------------------------
// rc4_smem_mux
// 3:1 combinational mux onto the single-port 256x8 S-memory.
// Ports:
//   state                      : controller state, acts as the select
//   init_/ksa_/dec_ addr,data,wren : per-engine memory requests
//   mem_address, mem_data, wren    : to the S-memory
// Only the engine owning the current phase reaches the memory; in every other
// state the port is parked at address 0, data 0, write disabled, so a stray
// write enable from an idle engine can never corrupt S.
// -----------------------------------------------------------------------------
module rc4_smem_mux
    import rc4_pkg::*;
(
    input  rc4_ctrl_state_t      state,
    input  logic [SMEM_AW-1:0]   init_addr,
    input  logic [7:0]           init_data,
    input  logic                 init_wren,
    input  logic [SMEM_AW-1:0]   ksa_addr,
    input  logic [7:0]           ksa_data,
    input  logic                 ksa_wren,
    input  logic [SMEM_AW-1:0]   dec_addr,
    input  logic [7:0]           dec_data,
    input  logic                 dec_wren,
    output logic [SMEM_AW-1:0]   mem_address,
    output logic [7:0]           mem_data,
    output logic                 wren
);

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        wren        = 1'b0;
        case (state)
            ST_INIT, ST_INIT_WAIT: begin
                mem_address = init_addr;
                mem_data    = init_data;
                wren        = init_wren;
            end
            ST_KSA, ST_KSA_WAIT: begin
                mem_address = ksa_addr;
                mem_data    = ksa_data;
                wren        = ksa_wren;
            end
            ST_DEC, ST_DEC_WAIT: begin
                mem_address = dec_addr;
                mem_data    = dec_data;
                wren        = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_key_search_ctrl
// Sequencer for brute-force RC4 key search. For each candidate key it runs
// S-init, key scheduling and decrypt, watches every byte the decrypt engine
// writes to the output RAM, and either reports the key or moves to the next.
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   start               : one-cycle pulse, begins a search at KEY_MIN
//   secret_key          : current candidate key
//   *_start / *_done    : engine start pulses out, completion pulses in
//   *_addr/*_data/*_wren: engine S-memory requests (muxed onto mem_*/wren)
//   wren_ram, ram_data  : monitored decrypt output writes
//   busy, found, fail   : search status
//   state_dbg           : current sequencer state
//
// Engine handshake: a start output is high for exactly one cycle, in the state
// that launches that engine. The matching done input is a one-cycle pulse and
// is acted on only in that engine's WAIT state; a done pulse seen anywhere else
// is dropped. Both sides are pulses, there is no back-pressure.
// -----------------------------------------------------------------------------
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MIN = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF,
    parameter int               MSG_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [KEY_W-1:0]     secret_key,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 dec_start,
    input  logic                 init_done,
    input  logic                 ksa_done,
    input  logic                 dec_done,
    input  logic [SMEM_AW-1:0]   init_addr,
    input  logic [7:0]           init_data,
    input  logic                 init_wren,
    input  logic [SMEM_AW-1:0]   ksa_addr,
    input  logic [7:0]           ksa_data,
    input  logic                 ksa_wren,
    input  logic [SMEM_AW-1:0]   dec_addr,
    input  logic [7:0]           dec_data,
    input  logic                 dec_wren,
    output logic [SMEM_AW-1:0]   mem_address,
    output logic [7:0]           mem_data,
    output logic                 wren,
    input  logic                 wren_ram,
    input  logic [7:0]           ram_data,
    output logic                 busy,
    output logic                 found,
    output logic                 fail,
    output rc4_ctrl_state_t      state_dbg
);

    // One extra bit so the count can actually reach MSG_LEN.
    localparam int               CNT_W     = MSG_AW + 1;
    localparam logic [CNT_W-1:0] MSG_LEN_C = CNT_W'(MSG_LEN);

    rc4_ctrl_state_t  state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_MIN;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_FOUND, ST_FAIL: begin
                if (start) begin
                    key_d   = KEY_MIN;
                    state_d = ST_INIT;
                end
            end
            ST_INIT:      state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: if (init_done) state_d = ST_KSA;
            ST_KSA:       state_d = ST_KSA_WAIT;
            ST_KSA_WAIT:  if (ksa_done) state_d = ST_DEC;
            ST_DEC: begin
                bad_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                // A bad byte does not abort the engine; the verdict waits for
                // dec_done so the engines always finish a clean pass.
                if (wren_ram) begin
                    if (cnt_q < MSG_LEN_C) cnt_d = cnt_q + CNT_W'(1);
                    if (!is_valid_char(ram_data)) bad_d = 1'b1;
                end
                if (dec_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!bad_q && (cnt_q == MSG_LEN_C)) state_d = ST_FOUND;
                else                                 state_d = ST_NEXT_KEY;
            end
            ST_NEXT_KEY: begin
                // The last key is reported as-is on failure; no wrap.
                if (key_q == KEY_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    key_d   = key_q + KEY_W'(1);
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign secret_key = key_q;
    assign init_start = (state_q == ST_INIT);
    assign ksa_start  = (state_q == ST_KSA);
    assign dec_start  = (state_q == ST_DEC);
    assign found      = (state_q == ST_FOUND);
    assign fail       = (state_q == ST_FAIL);
    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_FOUND) || (state_q == ST_FAIL));
    assign state_dbg  = state_q;

    rc4_smem_mux u_smem_mux (
        .state       (state_q),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_data    (ksa_data),
        .ksa_wren    (ksa_wren),
        .dec_addr    (dec_addr),
        .dec_data    (dec_data),
        .dec_wren    (dec_wren),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .wren        (wren)
    );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
// Directed bench for rc4_key_search_ctrl with fixed-latency engine stubs
// (init 260, ksa 770, dec 100 cycles from start pulse to done pulse) and a
// search space of keys 0..3. The reference model describes a search as a cycle
// offset from the accepted start: each key occupies PER_KEY cycles, and the
// start pulses, memory owner and key value follow from that offset.
// -----------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;
    import rc4_pkg::*;

    localparam int L_INIT   = 260;
    localparam int L_KSA    = 770;
    localparam int L_DEC    = 100;
    localparam int NKEYS    = 4;
    // INIT, KSA, DEC, CHECK and NEXT_KEY are one cycle each; each WAIT lasts
    // exactly its engine latency (ending on the done cycle).
    localparam int PER_KEY  = L_INIT + L_KSA + L_DEC + 5;
    localparam int PH_KSA   = L_INIT + 1;
    localparam int PH_DEC   = L_INIT + L_KSA + 2;
    localparam int PH_CHECK = PER_KEY - 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic            start;
    logic [23:0]     secret_key;
    logic            init_start, ksa_start, dec_start;
    logic            init_done, ksa_done, dec_done;
    logic [7:0]      init_addr, init_data, ksa_addr, ksa_data, dec_addr, dec_data;
    logic            init_wren, ksa_wren, dec_wren;
    logic [7:0]      mem_address, mem_data;
    logic            wren;
    logic            wren_ram;
    logic [7:0]      ram_data;
    logic            busy, found, fail;
    rc4_ctrl_state_t dut_state;

    rc4_key_search_ctrl #(
        .KEY_MIN (24'h000000),
        .KEY_MAX (24'h000003),
        .MSG_LEN (32)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .secret_key (secret_key),
        .init_start (init_start), .ksa_start (ksa_start), .dec_start (dec_start),
        .init_done (init_done), .ksa_done (ksa_done), .dec_done (dec_done),
        .init_addr (init_addr), .init_data (init_data), .init_wren (init_wren),
        .ksa_addr (ksa_addr), .ksa_data (ksa_data), .ksa_wren (ksa_wren),
        .dec_addr (dec_addr), .dec_data (dec_data), .dec_wren (dec_wren),
        .mem_address (mem_address), .mem_data (mem_data), .wren (wren),
        .wren_ram (wren_ram), .ram_data (ram_data),
        .busy (busy), .found (found), .fail (fail), .state_dbg (dut_state)
    );

    // ---------------- per-key decrypt stub configuration ----------------
    int         n_bytes [NKEYS];
    int         bad_pos [NKEYS];
    logic [7:0] bad_val [NKEYS];
    logic [7:0] valid_tab [4] = '{8'h20, 8'h61, 8'h7A, 8'h6D};
    bit         stray_en;

    function automatic bit pass_ok(input int k);
        if (k < 0 || k >= NKEYS) return 1'b0;
        return (n_bytes[k] >= 32) && !((bad_pos[k] >= 0) && (bad_pos[k] < n_bytes[k]));
    endfunction

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 searching, 2 found, 3 failed
    int          m_mode;
    int          m_off;
    logic [23:0] m_key;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0;
            m_off  <= 0;
            m_key  <= 24'h0;
        end else if (m_mode == 1) begin
            if ((m_off % PER_KEY) == PH_CHECK && pass_ok(m_off / PER_KEY)) begin
                m_mode <= 2;
                m_key  <= 24'(m_off / PER_KEY);
            end else if ((m_off % PER_KEY) == PER_KEY - 1 && (m_off / PER_KEY) == NKEYS - 1) begin
                m_mode <= 3;
                m_key  <= 24'(NKEYS - 1);
            end else begin
                m_off <= m_off + 1;
            end
        end else if (start) begin
            m_mode <= 1;
            m_off  <= 0;
        end
    end

    // ---------------- engine stubs ----------------
    initial begin
        int ic, kc, dc, dpos, kidx;
        ic = 0; kc = 0; dc = 0; dpos = 0; kidx = 0;
        init_done = 1'b0; ksa_done = 1'b0; dec_done = 1'b0;
        wren_ram = 1'b0; ram_data = 8'h00;
        init_addr = 8'h0; init_data = 8'h0; init_wren = 1'b0;
        ksa_addr = 8'h0; ksa_data = 8'h0; ksa_wren = 1'b0;
        dec_addr = 8'h0; dec_data = 8'h0; dec_wren = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            init_done = 1'b0; ksa_done = 1'b0; dec_done = 1'b0;
            wren_ram = 1'b0; ram_data = 8'h00;
            // every engine keeps requesting the memory, selected or not
            init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
            ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wren  = 1'($urandom);
            dec_addr  = 8'($urandom); dec_data  = 8'($urandom); dec_wren  = 1'($urandom);
            if (reset === 1'b1) begin
                ic = 0; kc = 0; dc = 0;
            end else begin
                if (ic > 0) begin ic--; if (ic == 0) init_done = 1'b1; end
                if (kc > 0) begin kc--; if (kc == 0) ksa_done = 1'b1; end
                if (dc > 0) begin
                    dc--;
                    if (dc == 0) begin
                        dec_done = 1'b1;
                    end else if (kidx < NKEYS && dpos < n_bytes[kidx]) begin
                        wren_ram = 1'b1;
                        ram_data = (dpos == bad_pos[kidx]) ? bad_val[kidx] : valid_tab[dpos % 4];
                        dpos++;
                    end
                end
                if (init_start === 1'b1) ic = L_INIT;
                if (ksa_start === 1'b1) kc = L_KSA;
                if (dec_start === 1'b1) begin
                    dc = L_DEC;
                    dpos = 0;
                    kidx = int'(secret_key);
                end
                if (stray_en && m_mode == 1 && (m_off % PER_KEY) == 100) begin
                    ksa_done = 1'b1;
                    dec_done = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int total, bad;
    int cyc_n;
    int init_cnt, t_first, t_second;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one cycle: compare at the falling edge, then step past it.
    task automatic cycle();
        logic [46:0] act, exp;
        int ph, k, sel;
        logic e_busy, e_found, e_fail, e_is, e_ks, e_ds, e_wren;
        logic [23:0] e_key;
        logic [7:0] e_addr, e_data;
        @(negedge clk);
        cyc_n++;
        if (chk_en) begin
            e_busy = 1'b0; e_found = 1'b0; e_fail = 1'b0;
            e_is = 1'b0; e_ks = 1'b0; e_ds = 1'b0;
            e_key = m_key; sel = 0;
            if (m_mode == 1) begin
                ph = m_off % PER_KEY;
                k  = m_off / PER_KEY;
                e_busy = 1'b1;
                e_key  = 24'(k);
                e_is   = (ph == 0);
                e_ks   = (ph == PH_KSA);
                e_ds   = (ph == PH_DEC);
                if (ph <= L_INIT)              sel = 1;
                else if (ph < PH_DEC)          sel = 2;
                else if (ph <= PH_DEC + L_DEC) sel = 3;
            end else if (m_mode == 2) begin
                e_found = 1'b1;
            end else if (m_mode == 3) begin
                e_fail = 1'b1;
            end
            e_wren = 1'b0; e_addr = 8'h0; e_data = 8'h0;
            case (sel)
                1: begin e_wren = init_wren; e_addr = init_addr; e_data = init_data; end
                2: begin e_wren = ksa_wren;  e_addr = ksa_addr;  e_data = ksa_data;  end
                3: begin e_wren = dec_wren;  e_addr = dec_addr;  e_data = dec_data;  end
                default: ;
            endcase
            exp = {e_busy, e_found, e_fail, e_is, e_ks, e_ds, e_wren, e_key, e_addr, e_data};
            act = {busy, found, fail, init_start, ksa_start, dec_start, wren,
                   secret_key, mem_address, mem_data};
            total++;
            if (act !== exp) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL cycle %0d outputs {busy,found,fail,starts,wren,key,addr,data}: got %h want %h (dut state %s)",
                             cyc_n, act, exp, dut_state.name());
            end
        end
        if (init_start === 1'b1) begin
            init_cnt++;
            if (init_cnt == 1) t_first = cyc_n;
            else if (init_cnt == 2) t_second = cyc_n;
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg(input int k, input int n, input int pos, input logic [7:0] v);
        n_bytes[k] = n;
        bad_pos[k] = pos;
        bad_val[k] = v;
    endtask

    task automatic pulse_start();
        init_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_end(input string name);
        int n;
        n = 0;
        while (!(found === 1'b1 || fail === 1'b1) && n < 6000) begin
            cycle();
            n++;
        end
        if (n >= 6000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no found/fail within 6000 cycles, want one", name);
        end
    endtask

    task automatic wait_off(input string name, input int target);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_off == target) && n < 6000) begin
            cycle();
            n++;
        end
        if (n >= 6000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got offset %0d want %0d", name, m_off, target);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        total = 0; bad = 0; cyc_n = 0;
        init_cnt = 0; t_first = 0; t_second = 0;
        chk_en = 1'b0; stray_en = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < NKEYS; k++) cfg(k, 32, -1, 8'h41);
        repeat (3) cycle();
        chk_en = 1'b1;
        cycle();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_key", 32'(secret_key), 32'd0);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_found_fail", 32'({found, fail}), 32'd0);
        reset = 1'b0;
        repeat (3) cycle();

        // 1: only key 2 decrypts to plaintext; bad bytes sit just outside the
        //    valid ranges on the other keys
        cfg(0, 32, 0, 8'h60);
        cfg(1, 32, 17, 8'h7B);
        cfg(2, 32, -1, 8'h00);
        cfg(3, 32, 31, 8'h1F);
        pulse_start();
        check("s1_first_init_pulse", 32'(init_start), 32'd1);
        run_to_end("s1");
        check("s1_found", 32'(found), 32'd1);
        check("s1_fail", 32'(fail), 32'd0);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_key", 32'(secret_key), 32'h000002);
        check("s1_init_pulses", 32'(init_cnt), 32'd3);
        check("s1_per_key_cycles", 32'(t_second - t_first), 32'd1135);

        // 2: no key works -> fail on key 3, no further INIT
        cfg(0, 32, 31, 8'h21);
        cfg(1, 0, -1, 8'h00);
        cfg(2, 20, -1, 8'h00);
        cfg(3, 32, 10, 8'h41);
        pulse_start();
        check("s2_found_cleared", 32'(found), 32'd0);
        run_to_end("s2");
        repeat (30) cycle();
        check("s2_fail", 32'(fail), 32'd1);
        check("s2_found", 32'(found), 32'd0);
        check("s2_key", 32'(secret_key), 32'h000003);
        check("s2_init_pulses", 32'(init_cnt), 32'd4);

        // 3: key 0 has 'A' at byte 5 -> rejected only after dec_done
        cfg(0, 32, 5, 8'h41);
        cfg(1, 32, -1, 8'h00);
        pulse_start();
        run_to_end("s3");
        check("s3_key", 32'(secret_key), 32'h000001);
        check("s3_found", 32'(found), 32'd1);
        check("s3_per_key_cycles", 32'(t_second - t_first), 32'd1135);

        // 4: key 0 short by one byte; key 1 overruns (count saturates)
        cfg(0, 31, -1, 8'h00);
        cfg(1, 40, -1, 8'h00);
        pulse_start();
        run_to_end("s4");
        check("s4_key", 32'(secret_key), 32'h000001);
        check("s4_init_pulses", 32'(init_cnt), 32'd2);

        // 5: reset in KSA_WAIT aborts; later start restarts cleanly
        cfg(0, 32, -1, 8'h00);
        pulse_start();
        wait_off("s5_ksa_wait", PH_KSA + 100);
        reset = 1'b1;
        cycle();
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_wren", 32'(wren), 32'd0);
        check("s5_rst_key", 32'(secret_key), 32'd0);
        cycle();
        reset = 1'b0;
        repeat (50) cycle();
        check("s5_no_pulse_after_reset", 32'(init_cnt), 32'd1);
        pulse_start();
        check("s5_restart_init", 32'(init_start), 32'd1);
        run_to_end("s5");
        check("s5_key", 32'(secret_key), 32'h000000);

        // 6: stray done pulses in INIT_WAIT, start during DEC_WAIT, only key 3 ok
        cfg(0, 32, 3, 8'h7B);
        cfg(1, 32, 3, 8'h7B);
        cfg(2, 32, 3, 8'h7B);
        cfg(3, 32, -1, 8'h00);
        stray_en = 1'b1;
        pulse_start();
        wait_off("s6_dec_wait", PER_KEY + PH_DEC + 40);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("s6_start_ignored_key", 32'(secret_key), 32'h000001);
        check("s6_start_ignored_busy", 32'(busy), 32'd1);
        run_to_end("s6");
        stray_en = 1'b0;
        check("s6_key", 32'(secret_key), 32'h000003);
        check("s6_found", 32'(found), 32'd1);
        check("s6_init_pulses", 32'(init_cnt), 32'd4);
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
